// File: rtl/dual_port_ram_pkg.sv
// Shared types and defaults for the parametrised simple-dual-port RAM.
// Imported by the interface, the read pipeline and the top.
package dual_port_ram_pkg;

  typedef enum logic {
    LowLatency,
    HighPerf
  } perf_e;

  typedef enum logic {
    StInit,
    StRun
  } ram_state_e;

  localparam int unsigned RamWidthDef = 8;
  localparam int unsigned RamDepthDef = 32;

  // Bits needed to encode addresses 0..depth-1 (at least one).
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w = 1;
    while (((depth - 1) >> w) != 0) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/dual_port_ram_if.sv
// Request/response bundle of the dual-port RAM: write port A, read port B,
// clear request and the tagged read response.
interface dual_port_ram_if
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = RamWidthDef,
  parameter int unsigned ADDR_W    = addr_width(RamDepthDef)
);

  logic                 clr;
  logic                 a_en;
  logic                 a_wen;
  logic [ADDR_W-1:0]    a_addr;
  logic [RAM_WIDTH-1:0] a_data;
  logic                 b_en;
  logic [ADDR_W-1:0]    b_addr;
  logic [RAM_WIDTH-1:0] rd_data;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_dv;
  logic                 busy;

  modport master (
    output clr, a_en, a_wen, a_addr, a_data, b_en, b_addr,
    input  rd_data, rd_addr, rd_dv, busy
  );

  modport slave (
    input  clr, a_en, a_wen, a_addr, a_data, b_en, b_addr,
    output rd_data, rd_addr, rd_dv, busy
  );

endinterface

// File: rtl/dual_port_ram_rd_pipe.sv
// Read response pipeline: one register stage for LowLatency, two for HighPerf.
// Data and address hold their last value; only dv pulses.
module dual_port_ram_rd_pipe
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = RamWidthDef,
  parameter int unsigned ADDR_W    = 5,
  parameter perf_e       PERF      = LowLatency
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_dv,
  input  logic [RAM_WIDTH-1:0] in_data,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 rd_dv,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic [ADDR_W-1:0]    rd_addr
);

  typedef struct packed {
    logic                 dv;
    logic [ADDR_W-1:0]    addr;
    logic [RAM_WIDTH-1:0] data;
  } rd_beat_t;

  rd_beat_t s1_q;
  rd_beat_t beat_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= '0;
    end else begin
      s1_q.dv <= in_dv;
      if (in_dv) begin
        s1_q.addr <= in_addr;
        s1_q.data <= in_data;
      end
    end
  end

  if (PERF == HighPerf) begin : g_high_perf
    rd_beat_t s2_q;

    // Second stage copies the already captured word, so later writes cannot alter it.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s2_q <= '0;
      end else begin
        s2_q.dv <= s1_q.dv;
        if (s1_q.dv) begin
          s2_q.addr <= s1_q.addr;
          s2_q.data <= s1_q.data;
        end
      end
    end

    assign beat_out = s2_q;
  end else begin : g_low_latency
    assign beat_out = s1_q;
  end

  assign rd_dv   = beat_out.dv;
  assign rd_addr = beat_out.addr;
  assign rd_data = beat_out.data;

endmodule

// File: rtl/dual_port_ram.sv
// Simple-dual-port RAM with write-first bypass, out-of-range protection and a
// clear engine that zeroes the array after reset or on a clr request.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = RamWidthDef,
  parameter int unsigned RAM_DEPTH = RamDepthDef,
  parameter perf_e       PERF      = LowLatency
) (
  input logic           clk,
  input logic           rstn,
  dual_port_ram_if.slave bus
);

  localparam int unsigned ADDR_W = addr_width(RAM_DEPTH);

  ram_state_e           state_q;
  logic [ADDR_W-1:0]    clr_cnt_q;
  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                 busy;
  logic                 a_in_range;
  logic                 b_in_range;
  logic                 wr_en;
  logic                 rd_req;
  logic [RAM_WIDTH-1:0] rd_word;

  assign busy       = (state_q == StInit);
  assign a_in_range = (32'(bus.a_addr) < RAM_DEPTH);
  assign b_in_range = (32'(bus.b_addr) < RAM_DEPTH);
  assign wr_en      = bus.a_en & bus.a_wen & a_in_range & ~busy;
  assign rd_req     = bus.b_en & ~busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (clr_cnt_q == ADDR_W'(RAM_DEPTH - 1)) begin
            state_q <= StRun;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (bus.clr) begin
            state_q   <= StInit;
            clr_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  // Array is never reset; the clear engine zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[bus.a_addr] <= bus.a_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (b_in_range) begin
      rd_word = (wr_en && (bus.a_addr == bus.b_addr)) ? bus.a_data : mem_q[bus.b_addr];
    end
  end

  dual_port_ram_rd_pipe #(
    .RAM_WIDTH(RAM_WIDTH),
    .ADDR_W   (ADDR_W),
    .PERF     (PERF)
  ) u_rd_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .in_dv  (rd_req),
    .in_data(rd_word),
    .in_addr(bus.b_addr),
    .rd_dv  (bus.rd_dv),
    .rd_data(bus.rd_data),
    .rd_addr(bus.rd_addr)
  );

  assign bus.busy = busy;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: three instances (32/LowLatency, 32/HighPerf, 20/HighPerf)
// share one stimulus stream; each is checked every cycle against its own model.
module tb_dual_port_ram;
  import dual_port_ram_pkg::*;

  localparam int NInst = 3;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b1;
  logic       clr    = 1'b0;
  logic       a_en   = 1'b0;
  logic       a_wen  = 1'b0;
  logic       b_en   = 1'b0;
  logic [4:0] a_addr = '0;
  logic [4:0] b_addr = '0;
  logic [7:0] a_data = '0;

  logic       o_busy    [NInst];
  logic       o_rd_dv   [NInst];
  logic [7:0] o_rd_data [NInst];
  logic [4:0] o_rd_addr [NInst];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NInst; g++) begin : g_inst
    localparam int unsigned Depth = (g == 2) ? 20 : 32;
    localparam perf_e       Perf  = (g == 0) ? LowLatency : HighPerf;
    localparam int          Lat   = (g == 0) ? 1 : 2;

    dual_port_ram_if #(.RAM_WIDTH(8), .ADDR_W(5)) bus ();

    assign bus.clr    = clr;
    assign bus.a_en   = a_en;
    assign bus.a_wen  = a_wen;
    assign bus.a_addr = a_addr;
    assign bus.a_data = a_data;
    assign bus.b_en   = b_en;
    assign bus.b_addr = b_addr;

    assign o_busy[g]    = bus.busy;
    assign o_rd_dv[g]   = bus.rd_dv;
    assign o_rd_data[g] = bus.rd_data;
    assign o_rd_addr[g] = bus.rd_addr;

    dual_port_ram #(
      .RAM_WIDTH(8),
      .RAM_DEPTH(Depth),
      .PERF     (Perf)
    ) u_dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
    );

    // Model: array, words still to clear, and pending responses tagged by due cycle.
    logic [7:0] mem_m [Depth];
    int clear_left = Depth;
    int cyc        = 0;
    int due_q[$];
    int data_q[$];
    int addr_q[$];
    int exp_dv     = 0;
    int exp_data   = 0;
    int exp_addr   = 0;

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        clear_left = Depth;
        due_q.delete();
        data_q.delete();
        addr_q.delete();
        exp_dv   = 0;
        exp_data = 0;
        exp_addr = 0;
      end else begin
        cyc++;
        if (clear_left > 0) begin
          mem_m[Depth - clear_left] = '0;
          clear_left--;
        end else begin
          if (a_en && a_wen && (int'(a_addr) < Depth)) mem_m[a_addr] = a_data;
          if (b_en) begin
            due_q.push_back(cyc + Lat - 1);
            data_q.push_back((int'(b_addr) < Depth) ? int'(mem_m[b_addr]) : 0);
            addr_q.push_back(int'(b_addr));
          end
          if (clr) clear_left = Depth;
        end
        exp_dv = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          exp_dv   = 1;
          exp_data = data_q.pop_front();
          exp_addr = addr_q.pop_front();
          void'(due_q.pop_front());
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("i%0d busy", g), int'(bus.busy), (clear_left != 0) ? 1 : 0);
      check($sformatf("i%0d rd_dv", g), int'(bus.rd_dv), exp_dv);
      check($sformatf("i%0d rd_data", g), int'(bus.rd_data), exp_data);
      check($sformatf("i%0d rd_addr", g), int'(bus.rd_addr), exp_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr   = 1'b0;
    a_en  = 1'b0;
    a_wen = 1'b0;
    b_en  = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    a_en   = 1'b1;
    a_wen  = 1'b1;
    a_addr = 5'(addr);
    a_data = 8'(data);
  endtask

  task automatic rd(input int addr);
    b_en   = 1'b1;
    b_addr = 5'(addr);
  endtask

  // Cycles until busy falls on the depth-32 and depth-20 instances (-1 if never).
  task automatic wait_clear(output int n0, output int n2);
    n0 = -1;
    n2 = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!o_busy[0] && n0 < 0) n0 = i;
      if (!o_busy[2] && n2 < 0) n2 = i;
      if (n0 >= 0 && n2 >= 0) break;
    end
  endtask

  initial begin
    int n0;
    int n2;
    #1 rstn = 1'b0;
    tick();
    check("reset busy", int'(o_busy[0]), 1);
    check("reset rd_dv", int'(o_rd_dv[1]), 0);
    check("reset rd_data", int'(o_rd_data[0]), 0);
    check("reset rd_addr", int'(o_rd_addr[2]), 0);
    repeat (2) tick();
    rstn = 1'b1;
    wait_clear(n0, n2);
    check("init cycles d32", n0, 32);
    check("init cycles d20", n2, 20);

    for (int i = 0; i < 32; i++) begin
      rd(i);
      tick();
      check("cleared rd_dv", int'(o_rd_dv[0]), 1);
      check("cleared rd_data", int'(o_rd_data[0]), 0);
      check("cleared rd_addr", int'(o_rd_addr[0]), i);
    end
    idle();
    repeat (2) tick();

    wr(3, 'hA5);
    tick();
    idle();
    rd(3);
    tick();
    idle();
    check("ll a5 dv", int'(o_rd_dv[0]), 1);
    check("ll a5 data", int'(o_rd_data[0]), 'hA5);
    check("ll a5 addr", int'(o_rd_addr[0]), 3);
    check("hp a5 dv early", int'(o_rd_dv[1]), 0);
    tick();
    check("hp a5 dv", int'(o_rd_dv[1]), 1);
    check("hp a5 data", int'(o_rd_data[1]), 'hA5);
    check("ll a5 dv pulse", int'(o_rd_dv[0]), 0);

    wr(7, 'h3C);
    rd(7);
    tick();
    check("write-first data", int'(o_rd_data[0]), 'h3C);
    b_en = 1'b0;
    wr(7, 'h99);
    tick();
    idle();
    check("hp captured dv", int'(o_rd_dv[1]), 1);
    check("hp captured data", int'(o_rd_data[1]), 'h3C);
    tick();

    wr(25, 'h55);
    tick();
    idle();
    wr(19, 'h11);
    rd(25);
    tick();
    idle();
    rd(19);
    tick();
    idle();
    check("oor dv", int'(o_rd_dv[2]), 1);
    check("oor data", int'(o_rd_data[2]), 0);
    check("oor addr", int'(o_rd_addr[2]), 25);
    check("d32 addr25 data", int'(o_rd_data[1]), 'h55);
    tick();
    check("d20 addr19 data", int'(o_rd_data[2]), 'h11);
    check("d20 addr19 addr", int'(o_rd_addr[2]), 19);

    for (int i = 0; i < 32; i++) begin
      wr(i, i + 1);
      tick();
    end
    idle();
    clr = 1'b1;
    rd(5);
    wr(9, 'h77);
    tick();
    idle();
    check("clr-cycle rd dv", int'(o_rd_dv[0]), 1);
    check("clr-cycle rd data", int'(o_rd_data[0]), 'h06);
    check("busy after clr", int'(o_busy[0]), 1);
    rd(12);
    tick();
    check("hp inflight dv", int'(o_rd_dv[1]), 1);
    check("hp inflight data", int'(o_rd_data[1]), 'h06);
    for (int k = 0; k < 5; k++) begin
      rd(k);
      tick();
      check("busy ll no dv", int'(o_rd_dv[0]), 0);
      check("busy hp no dv", int'(o_rd_dv[1]), 0);
    end
    idle();
    wait_clear(n0, n2);
    check("clr remaining d32", n0, 26);
    check("clr remaining d20", n2, 14);
    rd(5);
    tick();
    check("cleared @5", int'(o_rd_data[0]), 0);
    check("cleared @5 dv", int'(o_rd_dv[0]), 1);
    rd(9);
    tick();
    idle();
    check("clr-cycle write lost", int'(o_rd_data[0]), 0);
    tick();

    for (int i = 0; i < 600; i++) begin
      a_en   = 1'($urandom_range(0, 1));
      a_wen  = 1'($urandom_range(0, 1));
      a_addr = 5'($urandom_range(0, 31));
      a_data = 8'($urandom);
      b_en   = 1'($urandom_range(0, 1));
      b_addr = 5'($urandom_range(0, 31));
      clr    = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    wait_clear(n0, n2);
    check("random phase settles", int'(n0 >= 0 && n2 >= 0), 1);

    rd(3);
    tick();
    rd(4);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("async rst dv ll", int'(o_rd_dv[0]), 0);
    check("async rst dv hp", int'(o_rd_dv[1]), 0);
    check("async rst dv d20", int'(o_rd_dv[2]), 0);
    check("async rst busy", int'(o_busy[1]), 1);
    idle();
    repeat (2) tick();
    rstn = 1'b1;
    wait_clear(n0, n2);
    check("re-init cycles d32", n0, 32);
    check("re-init cycles d20", n2, 20);
    rd(3);
    tick();
    idle();
    check("after re-init data", int'(o_rd_data[0]), 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised simple-dual-port RAM, the successor to the fixed 8x32 RAM. It has one write port (A) and one read port (B), selectable latency mode (lowLatency / highPerf) and a built-in clear engine that zeroes the whole array after reset or on request. Read responses carry the request address and a data-valid strobe, matching the tRamOutData convention. It sits as the generic storage primitive under the MAC datapath buffers.

Parameters:
RAM_WIDTH, 8, data width in bits (>=1)
RAM_DEPTH, 32, number of words (>=2, need not be a power of 2)
PERF, lowLatency, tPerfEnum: lowLatency = 1-cycle read, highPerf = 2-cycle read with registered output
ADDR_W, log2(RAM_DEPTH-1), derived address width; not overridden

Ports:
clk  in  1  single clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
clr  in  1  single-cycle clear request
a_en  in  1  port A enable
a_wEn  in  1  port A write enable; write only when a_en & a_wEn
a_addr  in  ADDR_W  write address
a_data  in  RAM_WIDTH  write data
b_en  in  1  port B read request
b_addr  in  ADDR_W  read address
rd_data  out  RAM_WIDTH  read data
rd_addr  out  ADDR_W  address of the returned word
rd_dv  out  1  rd_data/rd_addr valid, one-cycle pulse per request
busy  out  1  clear engine active; ports are ignored while high

Behaviour:
- FSM states: INIT (clearing), RUN. Reset state is INIT with clear counter = 0.
- On rstn low: FSM goes to INIT, counter = 0, and all read pipeline registers flush. Outputs reset to rd_data=0, rd_addr=0, rd_dv=0, busy=1.
- Array contents are not reset directly; INIT writes 0 to address counter each cycle, 0..RAM_DEPTH-1.
- INIT lasts exactly RAM_DEPTH cycles after rstn deasserts. busy falls in the cycle after the last address is written. FSM then enters RUN.
- While busy=1: a_en, b_en and clr are ignored (not queued), and no rd_dv is produced.
- RUN, clr=1: FSM returns to INIT, counter = 0, busy=1 from the next cycle.
  - Any read already in the pipeline still completes with its captured data.
  - A port A write in the same cycle as clr is performed, then overwritten by the clear.
- Write: memory[a_addr] <= a_data at the edge where a_en & a_wEn & !busy.
- Read, lowLatency: a request sampled at edge t gives rd_dv=1 at t+1, with rd_data and rd_addr valid in that cycle.
- Read, highPerf: the same request gives rd_dv=1 at t+2 (extra output register stage).
- Back-to-back reads at 1 per cycle are supported in both modes; there is no backpressure.
- Same-cycle read/write to the same address is write-first: the read returns the new a_data.
- In highPerf, a write to the same address at t+1 does not alter a value already captured at t.
- Out-of-range address (>= RAM_DEPTH, possible when depth is not a power of 2):
  - write is discarded;
  - read returns rd_data=0 with rd_dv=1 and rd_addr echoed.
- rd_data holds its last value when rd_dv=0. Only rd_dv is a pulse.
- a_en=1 with a_wEn=0 is a no-op.

Decomposition:
- ramPckg holds: tPerfEnum; default constants cRamWidth/cRamDepth; the log2 dependency from funcPckg; enum tRamState {INIT, RUN}.
- Parametrised port structs stay local to the module, because packages cannot take per-instance parameters.
- One natural sub-module, ram_rd_pipe: the 1- or 2-stage read pipeline carrying data/addr/dv, selected by PERF and flushed by rstn.

Test Plan:
- Reset release, depth 32 -> busy=1 for exactly 32 cycles, then 0. A read of every address in lowLatency returns 0 with rd_dv 1 cycle after each request.
- Write 0xA5 @3, then read @3 in lowLatency and in highPerf -> rd_data=0xA5, rd_addr=3, rd_dv at +1 and +2 respectively.
- Same cycle: write 0x3C @7 and read @7 -> rd_data=0x3C (write-first). In highPerf, write 0x99 @7 one cycle after the read -> read still returns 0x3C.
- Fill 0..31 with addr+1, pulse clr, wait for busy to fall, then read 5 -> 0. A read @5 issued in the clr cycle still returns 0x06. Requests during busy produce no rd_dv.
- RAM_DEPTH=20: write 0x55 @25, read @25 -> rd_data=0, rd_dv=1, rd_addr=25. Read @19 works normally.
- Assert rstn low mid-stream, with highPerf reads in flight -> rd_dv=0 immediately with no pending pulses emitted. After release, busy repeats the full clear sequence.
